permute_dump_control: RTL and testbench
=======================================

Name: permute_dump_control

Overview:
- Control FSM that sequences the Keccak permute/dump datapath for SHAKE128/SHAKE256 through a full hash job: start, absorb, squeeze, and dump.
- Accepts padded rate blocks from the absorb stage via a valid/ready handshake and runs 24 rounds per block.
- Loads the PISO output buffer, streams words downstream under backpressure, and re-permutes until the requested output size is reached.

Parameters:
- N_ROUNDS, 24, Keccak-f rounds per permutation; must match the datapath round counter max (23+1).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- start  in  1  pulse; begin a new job (mode/size presented to datapath same cycle)
- busy  out  1  high from accepted start until DONE returns to IDLE
- block_valid  in  1  absorb stage offers a padded rate block
- block_last  in  1  qualifies block_valid; final input block
- block_ready  out  1  block accepted when block_valid&&block_ready
- out_valid  out  1  data_out word valid
- out_ready  in  1  downstream accepts word
- out_last  out  1  final word of the job (with out_valid)
- copy_control_regs_en, state_reset, absorb_enable, round_en, round_count_load  out  1 each  permute controls
- output_buffer_we, output_buffer_shift_en, output_counter_load, output_counter_rst  out  1 each  dump controls
- last_output_block_dump  out  1  registered last_output_block, held through the dump of that block
- round_done, output_buffer_empty, last_output_block, output_size_reached  in  1 each  datapath status

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0 except output_counter_rst=1. output_counter_rst is 1 only in reset and IDLE.
- IDLE: busy=0. On start: copy_control_regs_en=1, state_reset=1, round_count_load=1 for one cycle; go to WAIT_BLK. start in any other state is ignored.
- WAIT_BLK: block_ready=1. On handshake: round_en=1, absorb_enable=1 (round 0 absorbs the rate XOR); latch block_last into last_in; go to ABSORB_PERM. block_ready is 0 in every other state.
- ABSORB_PERM: round_en=1 every cycle, absorb_enable=0.
  - Exit on round_done&&round_en, after exactly N_ROUNDS round_en cycles including the handshake cycle.
  - Same exit cycle: round_count_load=1; go to WAIT_BLK if !last_in, else LOAD_BUF.
- LOAD_BUF (1 cycle): output_buffer_we=1, output_counter_load=1.
  - last_output_block_dump reg <= last_output_block; the datapath samples the reg value next cycle.
  - output_counter_load is asserted one cycle after the reg update: LOAD_BUF drives output_buffer_we; a 1-cycle LOAD_CNT drives output_counter_load. Total 2 cycles. Go to DUMP.
- DUMP: out_valid=1; output_buffer_shift_en = out_ready.
  - out_last = last_output_block_dump && output_buffer_empty.
  - On output_buffer_empty && out_ready (final word accepted):
    - output_size_reached=1 → DONE.
    - otherwise → SQZ_PERM with round_en=1, absorb_enable=0.
  - out_valid must not drop while !out_ready; word data is stable under backpressure.
- SQZ_PERM: same as ABSORB_PERM with absorb_enable=0. On round_done&&round_en: round_count_load=1 → LOAD_BUF.
- DONE (1 cycle): busy=0 next cycle; clear last_output_block_dump; → IDLE.
- Latency: start→block_ready = 1 cycle. Last block accept→first out_valid = N_ROUNDS+2 cycles.
- Simultaneous events:
  - round_done without round_en is ignored.
  - block_valid in a non-WAIT_BLK state is not accepted.
- Reset mid-operation returns to IDLE immediately with all controls deasserted. No partial output word is presented after reset.
- Output size zero: datapath reports output_size_reached after the first block. The controller still dumps that block (last_output_block_dump masks the word count); no output is skipped.

Decomposition:
- keccak_pkg: add typedef enum logic[2:0] pd_state_t {IDLE, WAIT_BLK, ABSORB_PERM, LOAD_BUF, LOAD_CNT, DUMP, SQZ_PERM, DONE}; add localparam N_ROUNDS=24.
- Single module; no sub-module. Output decode is combinational from state plus handshakes; last_in and last_output_block_dump are flops.
- Top-level wraps permute_dump_datapath + permute_dump_control.

Test Plan:
- SHAKE128, 1 input block, size 168 B: start, block_valid with block_last → 24 round_en cycles; absorb_enable only in the first; exactly 21 out_valid words; out_last on the 21st; busy drops.
- SHAKE256, 3 input blocks with block_valid gaps of 5 cycles → 3 handshakes, each followed by exactly 24 round_en; no round_en while waiting.
- SHAKE128, size 400 B → 3 dumps with 2 squeeze permutations (absorb_enable=0); final dump word count from remaining_valid_words; total out_valid&&out_ready = 50 words.
- Backpressure: out_ready toggled randomly (50%) during DUMP → shift_en only when out_ready; no word lost or duplicated versus reference SHAKE output.
- rst asserted mid-ABSORB_PERM (round 10) → next cycle IDLE, round_en=0, out_valid=0. A new start completes a correct hash.
- start pulsed during DUMP → ignored; current job output unchanged.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared types for the Keccak permute/dump slice.
// Controller states, round count and control bundles.
package keccak_pkg;

  localparam int N_ROUNDS = 24;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BLK,
    ABSORB_PERM,
    LOAD_BUF,
    LOAD_CNT,
    DUMP,
    SQZ_PERM,
    DONE
  } pd_state_t;

  typedef struct packed {
    logic copy_regs;
    logic state_reset;
    logic absorb_en;
    logic round_en;
    logic round_load;
  } perm_ctrl_t;

  typedef struct packed {
    logic buf_we;
    logic shift_en;
    logic cnt_load;
    logic cnt_rst;
  } dump_ctrl_t;

endpackage

// File: rtl/permute_dump_control.sv
// Job sequencer for the Keccak permute/dump datapath.
// Absorbs blocks, permutes, dumps words, re-squeezes.
module permute_dump_control
  import keccak_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  input  logic block_valid,
  input  logic block_last,
  output logic block_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic out_last,
  output logic copy_control_regs_en,
  output logic state_reset,
  output logic absorb_enable,
  output logic round_en,
  output logic round_count_load,
  output logic output_buffer_we,
  output logic output_buffer_shift_en,
  output logic output_counter_load,
  output logic output_counter_rst,
  output logic last_output_block_dump,
  input  logic round_done,
  input  logic output_buffer_empty,
  input  logic last_output_block,
  input  logic output_size_reached
);

  pd_state_t  state_q, state_d;
  logic       last_in_q, last_in_d;
  logic       lob_q, lob_d;
  perm_ctrl_t perm;
  dump_ctrl_t dump;
  logic       blk_rdy;
  logic       ovalid;
  logic       olast;
  logic       start_ok;

  // start is masked while reset is held so all controls stay low
  assign start_ok = start & rst;

  // State register and per-job flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_in_q <= 1'b0;
      lob_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_in_q <= last_in_d;
      lob_q     <= lob_d;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d   = state_q;
    last_in_d = last_in_q;
    lob_d     = lob_q;
    perm      = '0;
    dump      = '0;
    blk_rdy   = 1'b0;
    ovalid    = 1'b0;
    olast     = 1'b0;
    unique case (state_q)
      IDLE: begin
        dump.cnt_rst = 1'b1;
        if (start_ok) begin
          perm.copy_regs   = 1'b1;
          perm.state_reset = 1'b1;
          perm.round_load  = 1'b1;
          state_d          = WAIT_BLK;
        end
      end
      WAIT_BLK: begin
        blk_rdy = 1'b1;
        if (block_valid) begin
          perm.round_en  = 1'b1;
          perm.absorb_en = 1'b1;
          last_in_d      = block_last;
          state_d        = ABSORB_PERM;
        end
      end
      ABSORB_PERM: begin
        perm.round_en = 1'b1;
        if (round_done) begin
          perm.round_load = 1'b1;
          state_d = last_in_q ? LOAD_BUF
                              : WAIT_BLK;
        end
      end
      LOAD_BUF: begin
        dump.buf_we = 1'b1;
        lob_d       = last_output_block;
        state_d     = LOAD_CNT;
      end
      LOAD_CNT: begin
        dump.cnt_load = 1'b1;
        state_d       = DUMP;
      end
      DUMP: begin
        ovalid        = 1'b1;
        dump.shift_en = out_ready;
        olast         = lob_q & output_buffer_empty;
        if (output_buffer_empty && out_ready) begin
          if (output_size_reached) begin
            state_d = DONE;
          end else begin
            perm.round_en = 1'b1;
            state_d       = SQZ_PERM;
          end
        end
      end
      SQZ_PERM: begin
        perm.round_en = 1'b1;
        if (round_done) begin
          perm.round_load = 1'b1;
          state_d         = LOAD_BUF;
        end
      end
      DONE: begin
        lob_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy                   = (state_q != IDLE);
  assign block_ready            = blk_rdy;
  assign out_valid              = ovalid;
  assign out_last               = olast;
  assign copy_control_regs_en   = perm.copy_regs;
  assign state_reset            = perm.state_reset;
  assign absorb_enable          = perm.absorb_en;
  assign round_en               = perm.round_en;
  assign round_count_load       = perm.round_load;
  assign output_buffer_we       = dump.buf_we;
  assign output_buffer_shift_en = dump.shift_en;
  assign output_counter_load    = dump.cnt_load;
  assign output_counter_rst     = dump.cnt_rst;
  assign last_output_block_dump = lob_q;

endmodule

// File: tb/tb_permute_dump_control.sv
// Bench for permute_dump_control with a behavioural
// datapath model and permutation/word scoreboards.
module tb_permute_dump_control;
  import keccak_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic block_valid = 1'b0;
  logic block_last = 1'b0;
  logic out_ready = 1'b1;
  logic busy, block_ready, out_valid, out_last;
  logic copy_control_regs_en, state_reset;
  logic absorb_enable, round_en, round_count_load;
  logic output_buffer_we, output_buffer_shift_en;
  logic output_counter_load, output_counter_rst;
  logic last_output_block_dump;
  logic round_done, output_buffer_empty;
  logic last_output_block, output_size_reached;

  int n_checks = 0;
  int n_fail = 0;

  // datapath model state
  int rate = 21;
  int job_words = 0;
  int rc = 0;
  int tot = 0;
  int blk = 0;
  int idx = 0;
  bit bp = 1'b0;

  logic [15:0] pq[$];
  logic [16:0] wq[$];

  always #5 clk = ~clk;

  permute_dump_control dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .busy(busy),
    .block_valid(block_valid),
    .block_last(block_last),
    .block_ready(block_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .copy_control_regs_en(copy_control_regs_en),
    .state_reset(state_reset),
    .absorb_enable(absorb_enable),
    .round_en(round_en),
    .round_count_load(round_count_load),
    .output_buffer_we(output_buffer_we),
    .output_buffer_shift_en(output_buffer_shift_en),
    .output_counter_load(output_counter_load),
    .output_counter_rst(output_counter_rst),
    .last_output_block_dump(last_output_block_dump),
    .round_done(round_done),
    .output_buffer_empty(output_buffer_empty),
    .last_output_block(last_output_block),
    .output_size_reached(output_size_reached)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  assign round_done          = (rc == N_ROUNDS - 1);
  assign output_buffer_empty = (blk == 1);
  assign last_output_block   = (tot <= rate);
  assign output_size_reached = (tot <= 1);

  // behavioural datapath: round counter, word counters
  always @(posedge clk) begin
    if (copy_control_regs_en) begin
      tot <= job_words;
      idx <= 0;
    end
    if (round_count_load) rc <= 0;
    else if (round_en) rc <= rc + 1;
    if (output_counter_load)
      blk <= last_output_block_dump ? tot : rate;
    if (output_buffer_shift_en && blk != 0) begin
      blk <= blk - 1;
      tot <= tot - 1;
      idx <= idx + 1;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // permutation monitor: round_en count and absorb count
  int rcnt = 0;
  int acnt = 0;
  always @(negedge clk) begin
    logic [15:0] pe;
    if (!rst) begin
      rcnt = 0;
      acnt = 0;
    end else begin
      if (block_ready && !block_valid)
        check("idle_round", round_en, 1'b0);
      if (round_en) begin
        rcnt++;
        acnt += int'(absorb_enable);
        if (round_done) begin
          pe = (pq.size() != 0) ? pq.pop_front()
                                : 16'hffff;
          check("perm", {8'(rcnt), 8'(acnt)}, pe);
          rcnt = 0;
          acnt = 0;
        end
      end
    end
  end

  // word monitor: ordering, last flag, backpressure hold
  bit stall = 1'b0;
  int stall_idx = 0;
  always @(negedge clk) begin
    logic [16:0] we;
    if (!rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_word", idx, stall_idx);
      end
      if (out_valid || output_buffer_shift_en)
        check("shift_en", output_buffer_shift_en,
              out_valid & out_ready);
      if (out_valid && out_ready) begin
        we = (wq.size() != 0) ? wq.pop_front()
                              : 17'h1ffff;
        check("word", {out_last, 16'(idx)}, we);
      end
      stall = out_valid && !out_ready;
      stall_idx = idx;
    end
  end

  task automatic run_job(input int r, input int nblk,
                         input int gap, input int words,
                         input bit bpr, input bit poke);
    int n;
    int nsq;
    rate = r;
    job_words = words;
    nsq = (words + r - 1) / r - 1;
    for (int b = 0; b < nblk; b++)
      pq.push_back({8'(N_ROUNDS), 8'd1});
    for (int s = 0; s < nsq; s++)
      pq.push_back({8'(N_ROUNDS), 8'd0});
    for (int i = 0; i < words; i++)
      wq.push_back({i == words - 1, 16'(i)});
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    bp = bpr;
    @(negedge clk);
    check("start_rdy", block_ready, 1'b1);
    for (int b = 0; b < nblk; b++) begin
      if (b > 0) repeat (gap) @(posedge clk);
      @(posedge clk);
      #1;
      block_valid = 1'b1;
      block_last = (b == nblk - 1);
      n = 0;
      while (n < 200) begin
        @(negedge clk);
        if (block_ready) break;
        n++;
      end
      check("blk_wait", n < 200, 1'b1);
      @(posedge clk);
      #1;
      block_valid = 1'b0;
      block_last = 1'b0;
    end
    // handshake cycle is cycle 0
    n = 1;
    while (n < 200) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      n++;
    end
    check("latency", n, N_ROUNDS + 2);
    if (poke) begin
      start = 1'b1;
      #1;
      check("poke_copy", copy_control_regs_en, 1'b0);
      check("poke_busy", busy, 1'b1);
      @(posedge clk);
      #1 start = 1'b0;
    end
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("done_wait", n < 5000, 1'b1);
    check("busy_end", busy, 1'b0);
    check("cnt_rst_idle", output_counter_rst, 1'b1);
    check("lob_clear", last_output_block_dump, 1'b0);
    check("sb_words", wq.size(), 0);
    check("sb_perms", pq.size(), 0);
    bp = 1'b0;
  endtask

  task automatic abort_mid_absorb();
    int n;
    rate = 21;
    job_words = 21;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    block_valid = 1'b1;
    block_last = 1'b1;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (block_ready) break;
      n++;
    end
    check("ab_blk_wait", n < 200, 1'b1);
    @(posedge clk);
    #1;
    block_valid = 1'b0;
    block_last = 1'b0;
    // rounds 1..9 after the handshake round
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("ab_round_en", round_en, 1'b0);
    check("ab_absorb", absorb_enable, 1'b0);
    check("ab_out_valid", out_valid, 1'b0);
    check("ab_busy", busy, 1'b0);
    check("ab_ready", block_ready, 1'b0);
    check("ab_cnt_rst", output_counter_rst, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ab_idle_valid", out_valid, 1'b0);
    check("ab_idle_busy", busy, 1'b0);
  endtask

  initial begin
    #3;
    check("rst_busy", busy, 1'b0);
    check("rst_ready", block_ready, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_round_en", round_en, 1'b0);
    check("rst_cnt_rst", output_counter_rst, 1'b1);
    check("rst_lob", last_output_block_dump, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_job(21, 1, 0, 21, 1'b0, 1'b0);
    run_job(17, 3, 5, 8, 1'b0, 1'b0);
    run_job(21, 1, 0, 50, 1'b0, 1'b0);
    run_job(21, 1, 0, 50, 1'b1, 1'b1);
    abort_mid_absorb();
    run_job(21, 2, 3, 30, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
